isa_control_fsm: RTL and testbench
==================================

ISA_CONTROL_FSM -- requirements
Module: isa_control_fsm

Interface
REQ-001 The block SHALL use the following ports, in this order (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  instruction[6:0] from instruction register.
- mem_ready  in  1  memory handshake; access completes in the cycle it is 1.
- alu_op  out  alu_op_t (2)  ALU decoder class select.
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1, 11 zero.
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4.
- result_src  out  2  00 ALU-out register, 01 memory data, 10 ALU result direct.
- adr_src  out  1  0 PC, 1 result bus.
- ir_write  out  1  latch instruction and old PC.
- pc_update  out  1  PC <- result bus.
- reg_write  out  1  register-file write strobe.
- mem_write  out  1  data-memory write strobe.
- branch  out  1  datapath updates PC iff its branch condition holds.
- illegal  out  1  sticky unsupported-opcode flag.
REQ-002 The block SHALL have no parameters.

Function
REQ-003 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, LUI, ALUWB, BRANCH, JAL, JALR, JALR_LINK, TRAP; outputs gate on mem_ready only where stated.
REQ-004 Any output not listed for a state SHALL be 0 (alu_op = ALU_OP__MEMORY_ACCESS, all selects 00, strobes 0).
REQ-005 FETCH SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, ir_write=pc_update=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-006 DECODE SHALL drive alu_src_a=01, alu_src_b=01 (branch/JAL target), then decode opcode: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, 0010111->ALUWB, any other->TRAP.
REQ-007 MEMADR SHALL drive alu_src_a=10, alu_src_b=01; next MEMREAD if opcode[5]=0, else MEMWRITE.
REQ-008 MEMREAD SHALL drive adr_src=1, result_src=00; stay while mem_ready=0, else go to MEMWB.
REQ-009 MEMWB SHALL drive result_src=01, reg_write=1; next FETCH.
REQ-010 MEMWRITE SHALL drive adr_src=1, result_src=00, mem_write=1 every cycle until mem_ready=1, then go to FETCH.
REQ-011 EXECUTER SHALL drive alu_src_a=10, alu_src_b=00, alu_op=ALU_OP__REGISTER_OPERATION; next ALUWB.
REQ-012 EXECUTEI SHALL drive alu_src_a=10, alu_src_b=01, alu_op=ALU_OP__UNSET; next ALUWB.
REQ-013 LUI SHALL drive alu_src_a=11, alu_src_b=01; next ALUWB.
REQ-014 ALUWB SHALL drive result_src=00, reg_write=1; next FETCH.
REQ-015 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, alu_op=ALU_OP__BRANCH, result_src=00, branch=1; next FETCH.
REQ-016 JAL SHALL drive alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1; next ALUWB.
REQ-017 JALR SHALL drive alu_src_a=10, alu_src_b=01, result_src=10, pc_update=1; next JALR_LINK.
REQ-018 JALR_LINK SHALL drive alu_src_a=01, alu_src_b=10; next ALUWB.
REQ-019 TRAP SHALL be absorbing, with illegal=1 and all strobes 0, until reset.
REQ-020 Latency SHALL be (excluding wait cycles): R/I-ALU/LUI 4; AUIPC 3; load 5; store 4; branch 3; JAL 4; JALR 5 cycles.
REQ-021 ir_write, pc_update, mem_write, reg_write and branch SHALL never be asserted in the same cycle as reset.

Reset
REQ-022 While reset=1, state SHALL be FETCH, illegal SHALL be 0 and all strobes SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-instruction (including in a wait state or TRAP) SHALL abort it immediately; after release, the first edge SHALL evaluate FETCH.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- ADD (0110011), mem_ready=1: FETCH ir_write=1 -> DECODE -> EXECUTER alu_op=REGISTER_OPERATION -> ALUWB reg_write=1 -> FETCH; 4 cycles.
- LW with mem_ready low 3 cycles in FETCH and 2 in MEMREAD: ir_write only on ready cycle; MEMWB reg_write=1, result_src=01; 10 cycles total.
- SW, mem_ready low 2 cycles: mem_write=1 for exactly 3 cycles, adr_src=1; then FETCH.
- BEQ: BRANCH state alu_op=BRANCH, branch=1 exactly 1 cycle; JALR: pc_update in JALR, reg_write in ALUWB after JALR_LINK.
- Opcode 0000000: TRAP, illegal=1 held 20 cycles, no strobes; reset -> illegal=0, FETCH.
- Reset asserted asynchronously mid-MEMWRITE: mem_write drops before the next edge, state FETCH.

Source files
------------

// File: rtl/isa_control_fsm.sv
// -----------------------------------------------------------------------------
// isa_control_fsm
// Multi-cycle RV32I-style control sequencer (Moore machine). It walks each
// instruction through fetch, decode, execute, memory and write-back, and
// drives the datapath selects and strobes for the current state. Memory
// accesses stall on mem_ready. An unsupported opcode parks the machine in
// TRAP with a sticky illegal flag until reset.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset (forces FETCH, kills strobes)
//   opcode      instruction[6:0] from the instruction register
//   mem_ready   memory handshake; an access completes in the cycle it is 1
//   alu_op      ALU decoder class select
//   alu_src_a   00 PC, 01 old PC, 10 rs1, 11 zero
//   alu_src_b   00 rs2, 01 immediate, 10 constant 4
//   result_src  00 ALU-out register, 01 memory data, 10 ALU result direct
//   adr_src     memory address select: 0 PC, 1 result bus
//   ir_write    latch instruction and old PC
//   pc_update   PC <- result bus
//   reg_write   register-file write strobe
//   mem_write   data-memory write strobe
//   branch      datapath updates PC iff its branch condition holds
//   illegal     sticky unsupported-opcode flag
// -----------------------------------------------------------------------------
module isa_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       reg_write,
    output logic       mem_write,
    output logic       branch,
    output logic       illegal
);

    // ALU decoder classes
    localparam logic [1:0] ALU_OP__MEMORY_ACCESS      = 2'b00;
    localparam logic [1:0] ALU_OP__BRANCH             = 2'b01;
    localparam logic [1:0] ALU_OP__REGISTER_OPERATION = 2'b10;
    localparam logic [1:0] ALU_OP__UNSET              = 2'b11;

    // Operand A selects
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    // Operand B selects
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // Result bus selects
    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Supported opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // State encodings
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEMADR    = 4'd2;
    localparam logic [3:0] S_MEMREAD   = 4'd3;
    localparam logic [3:0] S_MEMWB     = 4'd4;
    localparam logic [3:0] S_MEMWRITE  = 4'd5;
    localparam logic [3:0] S_EXECUTER  = 4'd6;
    localparam logic [3:0] S_EXECUTEI  = 4'd7;
    localparam logic [3:0] S_LUI       = 4'd8;
    localparam logic [3:0] S_ALUWB     = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_JAL       = 4'd11;
    localparam logic [3:0] S_JALR      = 4'd12;
    localparam logic [3:0] S_JALR_LINK = 4'd13;
    localparam logic [3:0] S_TRAP      = 4'd14;

    logic [3:0] state;
    logic [3:0] state_next;

    // Raw strobes before reset gating
    logic ir_write_raw;
    logic pc_update_raw;
    logic reg_write_raw;
    logic mem_write_raw;
    logic branch_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (opcode)
                    OPC_LOAD,
                    OPC_STORE:  state_next = S_MEMADR;
                    OPC_RTYPE:  state_next = S_EXECUTER;
                    OPC_ITYPE:  state_next = S_EXECUTEI;
                    OPC_BRANCH: state_next = S_BRANCH;
                    OPC_JAL:    state_next = S_JAL;
                    OPC_JALR:   state_next = S_JALR;
                    OPC_LUI:    state_next = S_LUI;
                    OPC_AUIPC:  state_next = S_ALUWB;
                    default:    state_next = S_TRAP;
                endcase
            end
            // opcode[5] separates store (0100011) from load (0000011)
            S_MEMADR:    state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB:     state_next = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECUTER:  state_next = S_ALUWB;
            S_EXECUTEI:  state_next = S_ALUWB;
            S_LUI:       state_next = S_ALUWB;
            S_ALUWB:     state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JAL:       state_next = S_ALUWB;
            S_JALR:      state_next = S_JALR_LINK;
            S_JALR_LINK: state_next = S_ALUWB;
            S_TRAP:      state_next = S_TRAP;
            default:     state_next = S_TRAP;
        endcase
    end

    // Moore output decode; only FETCH looks at mem_ready
    always_comb begin
        alu_op        = ALU_OP__MEMORY_ACCESS;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        result_src    = RES_ALU_OUT;
        adr_src       = 1'b0;
        ir_write_raw  = 1'b0;
        pc_update_raw = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        branch_raw    = 1'b0;
        unique case (state)
            S_FETCH: begin
                adr_src       = 1'b0;
                alu_src_a     = SRC_A_PC;
                alu_src_b     = SRC_B_FOUR;
                result_src    = RES_ALU;
                ir_write_raw  = mem_ready;
                pc_update_raw = mem_ready;
            end
            S_DECODE: begin
                // Precompute branch / JAL target into the ALU-out register
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALU_OUT;
            end
            S_MEMWB: begin
                result_src    = RES_MEM;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                result_src    = RES_ALU_OUT;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_OP__REGISTER_OPERATION;
            end
            S_EXECUTEI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP__UNSET;
            end
            S_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
            end
            S_ALUWB: begin
                result_src    = RES_ALU_OUT;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_OP__BRANCH;
                result_src = RES_ALU_OUT;
                branch_raw = 1'b1;
            end
            S_JAL: begin
                // PC <- target held from DECODE; old PC + 4 computed for link
                alu_src_a     = SRC_A_OLD_PC;
                alu_src_b     = SRC_B_FOUR;
                result_src    = RES_ALU_OUT;
                pc_update_raw = 1'b1;
            end
            S_JALR: begin
                alu_src_a     = SRC_A_RS1;
                alu_src_b     = SRC_B_IMM;
                result_src    = RES_ALU;
                pc_update_raw = 1'b1;
            end
            S_JALR_LINK: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_FOUR;
            end
            S_TRAP: begin
                // All selects and strobes stay at their idle values
            end
            default: begin
            end
        endcase
    end

    // Strobes are gated combinationally so they drop the instant reset
    // rises, without waiting for the state register to settle.
    assign ir_write  = ir_write_raw  & ~reset;
    assign pc_update = pc_update_raw & ~reset;
    assign reg_write = reg_write_raw & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign branch    = branch_raw    & ~reset;
    assign illegal   = (state == S_TRAP) & ~reset;

endmodule

// File: tb/tb_isa_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_isa_control_fsm
// Scoreboard bench for isa_control_fsm. The driver turns each instruction into
// its list of phases (from the opcode class), expands waits on mem_ready, and
// pushes one expected output vector per cycle. A separate monitor pops and
// compares on every cycle. Instruction latency is also checked against the
// per-class cycle counts.
// -----------------------------------------------------------------------------
module tb_isa_control_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       illegal;

    isa_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_update  (pc_update),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .branch     (branch),
        .illegal    (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed observation:
    // {alu_op, src_a, src_b, result_src, adr_src, ir_write, pc_update,
    //  reg_write, mem_write, branch, illegal}
    logic [14:0] act;
    assign act = {alu_op, alu_src_a, alu_src_b, result_src, adr_src,
                  ir_write, pc_update, reg_write, mem_write, branch, illegal};

    // ALU class codes
    localparam int OP_MEM = 0;
    localparam int OP_BR  = 1;
    localparam int OP_REG = 2;
    localparam int OP_IMM = 3;

    typedef struct {
        logic [14:0] v;
        int          kind;   // 0 single cycle, 1 fetch wait, 2 memory wait
    } step_t;

    step_t       seq[$];
    logic [14:0] exp_q[$];
    int          total;
    int          bad;
    bit          drv_done;

    function automatic logic [14:0] vec(int op, int a, int b, int rs, int adr,
                                        int irw, int pcu, int rw, int mw,
                                        int br, int ill);
        logic [14:0] r;
        r = {op[1:0], a[1:0], b[1:0], rs[1:0], adr[0], irw[0], pcu[0],
             rw[0], mw[0], br[0], ill[0]};
        return r;
    endfunction

    // Idle FETCH outputs, also what reset forces
    function automatic logic [14:0] rst_vec();
        return vec(OP_MEM, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check(input string name, input logic [14:0] got,
                         input logic [14:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Cycle count per instruction class, excluding wait cycles
    function automatic int base_latency(input logic [6:0] o);
        case (o)
            7'b0110011, 7'b0010011, 7'b0110111: return 4;
            7'b0010111: return 3;
            7'b0000011: return 5;
            7'b0100011: return 4;
            7'b1100011: return 3;
            7'b1101111: return 4;
            7'b1100111: return 5;
            default:    return 0;
        endcase
    endfunction

    function automatic bit uses_mem(input logic [6:0] o);
        return (o == 7'b0000011) || (o == 7'b0100011);
    endfunction

    function automatic step_t mk(input logic [14:0] v, input int kind);
        step_t s;
        s.v    = v;
        s.kind = kind;
        return s;
    endfunction

    // Phase list for one instruction, from the opcode class
    task automatic build_seq(input logic [6:0] o);
        step_t aluwb;
        aluwb = mk(vec(OP_MEM, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0);
        seq.delete();
        seq.push_back(mk(rst_vec(), 1));
        seq.push_back(mk(vec(OP_MEM, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0));
        case (o)
            7'b0000011: begin
                seq.push_back(mk(vec(OP_MEM, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0));
                seq.push_back(mk(vec(OP_MEM, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 2));
                seq.push_back(mk(vec(OP_MEM, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0), 0));
            end
            7'b0100011: begin
                seq.push_back(mk(vec(OP_MEM, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0));
                seq.push_back(mk(vec(OP_MEM, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), 2));
            end
            7'b0110011: begin
                seq.push_back(mk(vec(OP_REG, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0));
                seq.push_back(aluwb);
            end
            7'b0010011: begin
                seq.push_back(mk(vec(OP_IMM, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0));
                seq.push_back(aluwb);
            end
            7'b0110111: begin
                seq.push_back(mk(vec(OP_MEM, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0));
                seq.push_back(aluwb);
            end
            7'b0010111: seq.push_back(aluwb);
            7'b1100011:
                seq.push_back(mk(vec(OP_BR, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0));
            7'b1101111: begin
                seq.push_back(mk(vec(OP_MEM, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0), 0));
                seq.push_back(aluwb);
            end
            7'b1100111: begin
                seq.push_back(mk(vec(OP_MEM, 2, 1, 2, 0, 0, 1, 0, 0, 0, 0), 0));
                seq.push_back(mk(vec(OP_MEM, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0), 0));
                seq.push_back(aluwb);
            end
            default:
                seq.push_back(mk(vec(OP_MEM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0));
        endcase
    endtask

    // Called aligned to a falling edge; returns aligned to a falling edge
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom);
            exp_q.push_back(rst_vec());
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    // Runs one instruction; fw/mw are wait cycles in FETCH / memory phase.
    // An illegal opcode sits in TRAP for trap_cycles, then is reset.
    task automatic run_instr(input logic [6:0] o, input int fw, input int mw,
                             input int trap_cycles);
        int cycles;
        int waits;
        logic [14:0] e;
        build_seq(o);
        opcode = o;
        cycles = 0;
        foreach (seq[k]) begin
            if (seq[k].kind == 0) begin
                int reps;
                reps = (is_legal(o) || k < 2) ? 1 : trap_cycles;
                for (int r = 0; r < reps; r++) begin
                    mem_ready = 1'($urandom);
                    exp_q.push_back(seq[k].v);
                    cycles++;
                    @(negedge clk);
                end
            end else begin
                waits = (seq[k].kind == 1) ? fw : mw;
                for (int w = 0; w <= waits; w++) begin
                    mem_ready = (w == waits);
                    e = seq[k].v;
                    if (seq[k].kind == 1 && mem_ready) begin
                        e[5] = 1'b1;
                        e[4] = 1'b1;
                    end
                    exp_q.push_back(e);
                    cycles++;
                    @(negedge clk);
                end
            end
        end
        if (is_legal(o)) begin
            check_int("latency", cycles,
                      base_latency(o) + fw + (uses_mem(o) ? mw : 0));
        end else begin
            do_reset(2);
        end
    endtask

    // Store stalled in MEMWRITE, then reset raised between clock edges
    task automatic sw_async_abort();
        opcode    = 7'b0100011;
        mem_ready = 1'b1;
        exp_q.push_back(vec(OP_MEM, 0, 2, 2, 0, 1, 1, 0, 0, 0, 0));
        @(negedge clk);
        exp_q.push_back(vec(OP_MEM, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        exp_q.push_back(vec(OP_MEM, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(vec(OP_MEM, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
            if (i == 0) @(negedge clk);
        end
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_outputs", act, rst_vec());
        check_int("async_rst_mem_write", int'(mem_write), 0);
        @(negedge clk);
        exp_q.push_back(rst_vec());
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one output vector per cycle, compared against the scoreboard
    initial begin
        logic [14:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", act, e);
            end
        end
    end

    logic [6:0] legal_ops[9];

    initial begin
        logic [6:0] o;
        int guard;
        total     = 0;
        bad       = 0;
        drv_done  = 1'b0;
        reset     = 1'b1;
        opcode    = 7'b0110011;
        mem_ready = 1'b0;
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                      7'b0010111};

        @(negedge clk);
        do_reset(3);

        // Directed scenarios
        run_instr(7'b0110011, 0, 0, 0);   // ADD
        run_instr(7'b0000011, 3, 2, 0);   // LW, 10 cycles
        run_instr(7'b0100011, 0, 2, 0);   // SW, mem_write for 3 cycles
        run_instr(7'b1100011, 0, 0, 0);   // BEQ
        run_instr(7'b1100111, 0, 0, 0);   // JALR
        run_instr(7'b0000000, 0, 0, 20);  // TRAP held 20 cycles, then reset
        sw_async_abort();

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                guard = 0;
                do begin
                    o = 7'($urandom_range(0, 127));
                    guard++;
                end while (is_legal(o) && guard < 100);
                if (is_legal(o)) o = 7'b1111111;
                run_instr(o, 0, 0, $urandom_range(1, 6));
            end else begin
                o = legal_ops[$urandom_range(0, 8)];
                run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), 0);
            end
        end

        drv_done = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #3;
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
